// File: rtl/glip_uart_credit_scheduler_pkg.sv
// Shared definitions for the GLIP UART credit scheduler: credit width, maximum
// credit per message, control escape byte and the request FSM state type.
package glip_uart_credit_scheduler_pkg;

  localparam int CREDIT_WIDTH = 15;
  localparam logic [CREDIT_WIDTH-1:0] MAX_CREDIT = 15'h7fff;
  localparam logic [7:0] CTRL_ESCAPE = 8'hfe;

  typedef enum logic {
    CREDIT_STATE_IDLE    = 1'b0,
    CREDIT_STATE_REQUEST = 1'b1
  } credit_state_t;

  // One credit message can carry at most MAX_CREDIT words.
  function automatic logic [CREDIT_WIDTH-1:0] min_grant(input logic [15:0] free_slots);
    logic [CREDIT_WIDTH-1:0] result;
    if (free_slots > {1'b0, MAX_CREDIT}) begin
      result = MAX_CREDIT;
    end else begin
      result = free_slots[CREDIT_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/glip_uart_sat_counter.sv
// 16-bit saturating up/down counter: adds a value and optionally decrements by
// one each cycle, clamping at 0xFFFF / 0 and flagging the clamped cycle.
module glip_uart_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] add,
  input  logic        dec,
  output logic [15:0] value,
  output logic        overflow,
  output logic        underflow
);

  logic [17:0] net;
  logic [15:0] value_next;

  // Bit 17 acts as the sign of the net result, bit 16 as the carry above 0xFFFF.
  always_comb begin
    net        = {2'b00, value} + {2'b00, add} - {17'd0, dec};
    underflow  = net[17];
    overflow   = !net[17] && net[16];
    value_next = net[15:0];
    if (overflow) begin
      value_next = 16'hffff;
    end else if (underflow) begin
      value_next = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0000;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/glip_uart_credit_scheduler.sv
// UART backend flow control: tracks remote credit for can_send and schedules
// local credit messages. Define GLIP_UART_CREDIT_TIMEOUT_EN to flush small credits after idle time.
module glip_uart_credit_scheduler
  import glip_uart_credit_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH       = 1024,
  parameter int CREDIT_THRESHOLD = 256
`ifdef GLIP_UART_CREDIT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES   = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    transfer,
  input  logic [CREDIT_WIDTH-1:0] rcv_credit,
  input  logic                    rcv_credit_en,
  input  logic                    ingress_consumed,
  output logic                    can_send,
  output logic [CREDIT_WIDTH-1:0] credit,
  output logic                    credit_en,
  input  logic                    credit_ack,
  output logic                    error
);

  localparam logic [15:0] DEPTH     = 16'(FIFO_DEPTH);
  localparam logic [15:0] THRESHOLD = 16'(CREDIT_THRESHOLD);

  credit_state_t           state;
  credit_state_t           state_next;
  logic [15:0]             tx_credit;
  logic [15:0]             tx_add;
  logic                    tx_overflow;
  logic                    tx_underflow;
  logic [15:0]             rx_free;
  logic [15:0]             rx_free_next;
  logic [16:0]             rx_sum;
  logic                    rx_overflow;
  logic                    grant;
  logic [CREDIT_WIDTH-1:0] grant_value;
  logic                    flush;
  logic                    ack_error;

  assign tx_add = rcv_credit_en ? {1'b0, rcv_credit} : 16'd0;

  glip_uart_sat_counter u_tx_credit (
    .clk       (clk),
    .rst       (rst),
    .add       (tx_add),
    .dec       (transfer),
    .value     (tx_credit),
    .overflow  (tx_overflow),
    .underflow (tx_underflow)
  );

  assign can_send    = (tx_credit != 16'd0);
  assign credit_en   = (state == CREDIT_STATE_REQUEST);
  assign grant_value = min_grant(rx_free);

`ifdef GLIP_UART_CREDIT_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_cnt;
  logic        below_threshold;

  // Only sub-threshold, non-empty free space ages toward a forced flush.
  assign below_threshold = (rx_free != 16'd0) && (rx_free < THRESHOLD);
  assign flush           = below_threshold && (idle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 16'd0;
    end else if (grant || (rx_free == 16'd0)) begin
      idle_cnt <= 16'd0;
    end else if ((state == CREDIT_STATE_IDLE) && below_threshold) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    ack_error  = 1'b0;
    unique case (state)
      CREDIT_STATE_IDLE: begin
        ack_error = credit_ack;
        if ((rx_free >= THRESHOLD) || flush) begin
          grant      = 1'b1;
          state_next = CREDIT_STATE_REQUEST;
        end
      end
      CREDIT_STATE_REQUEST: begin
        if (credit_ack) begin
          state_next = CREDIT_STATE_IDLE;
        end
      end
    endcase
  end

  // A slot freed in the grant cycle lands on top of the post-grant remainder.
  always_comb begin
    rx_sum       = {1'b0, rx_free - (grant ? {1'b0, grant_value} : 16'd0)} + {16'd0, ingress_consumed};
    rx_overflow  = (rx_sum > {1'b0, DEPTH});
    rx_free_next = rx_overflow ? DEPTH : rx_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CREDIT_STATE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_free <= DEPTH;
      credit  <= '0;
      error   <= 1'b0;
    end else begin
      rx_free <= rx_free_next;
      if (grant) begin
        credit <= grant_value;
      end
      if (tx_overflow || tx_underflow || rx_overflow || ack_error) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/glip_uart_credit_scheduler.md
Name: glip_uart_credit_scheduler

Overview:
Flow-control controller for the UART backend. It tracks remote credit, i.e. how many user words the far side can still accept, and drives `can_send` toward the egress multiplexer. It also accumulates freed local ingress buffer slots and schedules credit messages through the egress credit request/ack handshake. It sits between the ingress parser, the ingress FIFO read side and the egress control block.

Parameters:
FIFO_DEPTH, 1024, local ingress buffer depth in words; initial credit granted after reset; 1..32767.
CREDIT_THRESHOLD, 256, minimum ungranted free slots before a credit message is requested; 1..FIFO_DEPTH.
TIMEOUT_CYCLES, 4096, idle cycles before a sub-threshold credit is flushed; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
transfer  in  1  user word accepted by egress this cycle; consumes 1 remote credit
rcv_credit  in  15  credit value decoded from the remote side
rcv_credit_en  in  1  rcv_credit valid, single-cycle pulse
ingress_consumed  in  1  user read one word from the ingress FIFO; frees one local slot
can_send  out  1  remote credit > 0
credit  out  15  credit value to transmit; stable while credit_en is high
credit_en  out  1  credit message request to egress
credit_ack  in  1  egress finished sending the credit message
error  out  1  sticky protocol error

Behaviour:
- Reset values: tx_credit=0, rx_free=FIFO_DEPTH, credit=0, credit_en=0, error=0, state=IDLE, can_send=0.
- tx_credit, 16 bits unsigned, updated every cycle: next = tx_credit + (rcv_credit_en ? rcv_credit : 0) - transfer.
  - Sum > 0xFFFF: saturate at 0xFFFF and set error.
  - transfer while tx_credit==0 and no rcv_credit_en in the same cycle: hold at 0 and set error.
- can_send = (tx_credit != 0), combinational from the register. A credit received in cycle N gives can_send=1 in N+1.
- rx_free, 16 bits: free local slots not yet granted.
  - Increments on ingress_consumed.
  - Exceeding FIFO_DEPTH sets error and saturates at FIFO_DEPTH.
- FSM, 2 states:
  - IDLE: if rx_free >= CREDIT_THRESHOLD, then:
    - grant g = min(rx_free, 32767);
    - register credit<=g, credit_en<=1;
    - rx_free <= rx_free - g + ingress_consumed;
    - go to REQUEST.
  - REQUEST: credit_en stays 1 and credit is held. On credit_ack: credit_en<=0, go to IDLE.
  - credit_ack while in IDLE is ignored and sets error.
- Latency:
  - Condition true in IDLE at cycle N gives credit_en=1 at N+1.
  - credit_ack at cycle M gives credit_en=0 at M+1.
  - The earliest next credit_en is M+2.
- First request after reset: credit_en=1 on the 2nd cycle after rst deasserts, credit=FIFO_DEPTH.
- Simultaneous events:
  - transfer and rcv_credit_en both act in the same cycle.
  - ingress_consumed in the grant cycle is counted toward the next grant, not lost.
- error is sticky; only rst clears it.
- Reset mid-REQUEST aborts the request: credit_en=0 next cycle. The egress block shares rst, so no partial-message recovery is required here.

Optional Feature:
GLIP_UART_CREDIT_TIMEOUT_EN
- Defined:
  - A 16-bit idle counter counts cycles in IDLE with 0 < rx_free < CREDIT_THRESHOLD.
  - It clears on any grant, on rx_free==0 and on reset.
  - When it reaches TIMEOUT_CYCLES-1, IDLE grants rx_free even below threshold, with the same timing as a normal grant.
- Undefined: counter absent; grants only at threshold. A low-rate stream can stall until CREDIT_THRESHOLD words are consumed, which is acceptable by design.

Decomposition:
- Shared include glip_uart_defs.vh:
  - CREDIT_WIDTH=15, MAX_CREDIT=15'h7fff;
  - state encodings CREDIT_STATE_IDLE=0, CREDIT_STATE_REQUEST=1;
  - control escape byte 8'hfe.
- Sub-module glip_uart_sat_counter: 16-bit saturating up/down counter with add value, decrement and overflow/underflow flags.
  - Instantiated once for tx_credit.
  - rx_free logic stays inline.

Test Plan:
- Reset, FIFO_DEPTH=1024 -> credit_en=1 on cycle 2 after reset with credit=1024. Ack at cycle 5 -> credit_en=0 at cycle 6. rx_free=0; no further request.
- rcv_credit=3 pulse, then transfer on 3 consecutive cycles -> can_send 1,1,1 then 0. A 4th transfer sets error=1 and tx_credit stays 0.
- rcv_credit_en=1 with rcv_credit=5 and transfer=1 in the same cycle, from tx_credit=2 -> tx_credit=6.
- After the initial grant is acked, 256 ingress_consumed pulses -> credit_en with credit=256. ingress_consumed during the grant cycle yields rx_free=1 afterwards.
- GLIP_UART_CREDIT_TIMEOUT_EN, TIMEOUT_CYCLES=16, 10 ingress_consumed then idle -> credit_en with credit=10 after 16 IDLE cycles. Without the macro -> no request.
- rst asserted while credit_en=1 -> credit_en=0, error=0, can_send=0 next cycle. A fresh credit=1024 request follows after release.
